// File: rtl/sram_port0_arbiter.sv
// Round-robin arbiter sharing SRAM port 0 between the Wishbone slave and a core requester.
// One access in flight at a time; all SRAM command and response outputs are registered.
module sram_port0_arbiter #(
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [DATA_W-1:0] wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [DATA_W-1:0] wbs_dat_o,
    input  logic              c_req_i,
    input  logic              c_we_i,
    input  logic [3:0]        c_wmask_i,
    input  logic [ADDR_W-1:0] c_addr_i,
    input  logic [DATA_W-1:0] c_wdata_i,
    output logic              c_gnt_o,
    output logic              c_rvalid_o,
    output logic [DATA_W-1:0] c_rdata_o,
    output logic              o_csb0,
    output logic              o_web0,
    output logic [3:0]        o_wmask0,
    output logic [ADDR_W-1:0] o_waddr0,
    output logic [DATA_W-1:0] o_din0,
    input  logic [DATA_W-1:0] i_dout0
);

    localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic OWN_WB   = 1'b0;
    localparam logic OWN_CORE = 1'b1;

    logic [1:0]       r_state;
    logic             r_owner;
    logic             r_last_owner;
    logic             r_we;
    logic             r_wb_abort;
    logic [CNT_W-1:0] r_wait_cnt;

    logic [1:0]        w_state_nxt;
    logic              w_owner_nxt;
    logic              w_last_nxt;
    logic              w_we_nxt;
    logic              w_abort_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_csb_nxt;
    logic              w_web_nxt;
    logic [3:0]        w_wmask_nxt;
    logic [ADDR_W-1:0] w_waddr_nxt;
    logic [DATA_W-1:0] w_din_nxt;
    logic              w_ack_nxt;
    logic [DATA_W-1:0] w_wbdat_nxt;
    logic              w_gnt_nxt;
    logic              w_rvalid_nxt;
    logic [DATA_W-1:0] w_crdata_nxt;

    logic w_wb_req;
    logic w_grant_core;
    logic w_abort_cur;
    logic w_unused;

    assign w_wb_req     = wbs_cyc_i & wbs_stb_i;
    // On a tie the requester that did not own the previous access wins.
    assign w_grant_core = c_req_i & (~w_wb_req | (r_last_owner == OWN_WB));
    // A Wishbone master that drops cyc mid-access forfeits its ack.
    assign w_abort_cur  = r_wb_abort | ((r_owner == OWN_WB) & ~wbs_cyc_i);
    assign w_unused     = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};

    // State and registered-output update.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_WB;
            r_last_owner <= OWN_CORE;
            r_we         <= 1'b0;
            r_wb_abort   <= 1'b0;
            r_wait_cnt   <= '0;
            o_csb0       <= 1'b1;
            o_web0       <= 1'b1;
            o_wmask0     <= '0;
            o_waddr0     <= '0;
            o_din0       <= '0;
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= '0;
            c_gnt_o      <= 1'b0;
            c_rvalid_o   <= 1'b0;
            c_rdata_o    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_nxt;
            r_we         <= w_we_nxt;
            r_wb_abort   <= w_abort_nxt;
            r_wait_cnt   <= w_cnt_nxt;
            o_csb0       <= w_csb_nxt;
            o_web0       <= w_web_nxt;
            o_wmask0     <= w_wmask_nxt;
            o_waddr0     <= w_waddr_nxt;
            o_din0       <= w_din_nxt;
            wbs_ack_o    <= w_ack_nxt;
            wbs_dat_o    <= w_wbdat_nxt;
            c_gnt_o      <= w_gnt_nxt;
            c_rvalid_o   <= w_rvalid_nxt;
            c_rdata_o    <= w_crdata_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_last_nxt   = r_last_owner;
        w_we_nxt     = r_we;
        w_abort_nxt  = r_wb_abort;
        w_cnt_nxt    = r_wait_cnt;
        w_csb_nxt    = 1'b1;
        w_web_nxt    = 1'b1;
        w_wmask_nxt  = o_wmask0;
        w_waddr_nxt  = o_waddr0;
        w_din_nxt    = o_din0;
        w_ack_nxt    = 1'b0;
        w_wbdat_nxt  = wbs_dat_o;
        w_gnt_nxt    = 1'b0;
        w_rvalid_nxt = 1'b0;
        w_crdata_nxt = c_rdata_o;

        case (r_state)
            S_IDLE: begin
                if (w_wb_req | c_req_i) begin
                    w_state_nxt = S_CMD;
                    w_abort_nxt = 1'b0;
                    w_csb_nxt   = 1'b0;
                    if (w_grant_core) begin
                        w_owner_nxt = OWN_CORE;
                        w_last_nxt  = OWN_CORE;
                        w_we_nxt    = c_we_i;
                        w_web_nxt   = ~c_we_i;
                        w_wmask_nxt = c_we_i ? c_wmask_i : 4'b0000;
                        w_waddr_nxt = c_addr_i;
                        w_din_nxt   = c_wdata_i;
                        w_gnt_nxt   = 1'b1;
                    end else begin
                        w_owner_nxt = OWN_WB;
                        w_last_nxt  = OWN_WB;
                        w_we_nxt    = wbs_we_i;
                        w_web_nxt   = ~wbs_we_i;
                        w_wmask_nxt = wbs_we_i ? wbs_sel_i : 4'b0000;
                        w_waddr_nxt = wbs_adr_i[ADDR_W+1:2];
                        w_din_nxt   = wbs_dat_i;
                    end
                end
            end
            S_CMD: begin
                w_abort_nxt = w_abort_cur;
                if (r_we) begin
                    w_state_nxt = S_DONE;
                    w_ack_nxt   = (r_owner == OWN_WB) & ~w_abort_cur;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CNT_W'(READ_LAT - 1);
                end
            end
            S_WAIT: begin
                w_abort_nxt = w_abort_cur;
                if (r_wait_cnt == '0) begin
                    w_state_nxt = S_DONE;
                    if (r_owner == OWN_WB) begin
                        w_wbdat_nxt = i_dout0;
                        w_ack_nxt   = ~w_abort_cur;
                    end else begin
                        w_crdata_nxt = i_dout0;
                        w_rvalid_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_wait_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Directed bench for sram_port0_arbiter: one instance at READ_LAT=1, one at READ_LAT=2,
// each backed by a small behavioural SRAM.
module tb_sram_port0_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A (READ_LAT = 1)
    logic        cyc = 0, stb = 0, we = 0;
    logic [3:0]  sel = 0;
    logic [31:0] adr = 0, dat = 0;
    logic        ack;
    logic [31:0] dat_o;
    logic        creq = 0, cwe = 0;
    logic [3:0]  cmask = 0;
    logic [8:0]  caddr = 0;
    logic [31:0] cwdata = 0;
    logic        gnt, rvalid;
    logic [31:0] crdata;
    logic        csb0, web0;
    logic [3:0]  wmask0;
    logic [8:0]  waddr0;
    logic [31:0] din0;
    logic [31:0] dout0 = 0;

    // Instance B (READ_LAT = 2)
    logic        b_cyc = 0, b_stb = 0;
    logic [31:0] b_adr = 0;
    logic        b_ack, b_gnt, b_rvalid, b_csb, b_web;
    logic [31:0] b_dato, b_rdata, b_din;
    logic [3:0]  b_wmask;
    logic [8:0]  b_waddr;
    logic [31:0] b_dout = 0, b_rd1 = 0;

    logic [31:0] mem_a [512];
    logic [31:0] mem_b [512];

    sram_port0_arbiter #(.ADDR_W(9), .DATA_W(32), .READ_LAT(1)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .c_req_i(creq), .c_we_i(cwe), .c_wmask_i(cmask), .c_addr_i(caddr),
        .c_wdata_i(cwdata), .c_gnt_o(gnt), .c_rvalid_o(rvalid), .c_rdata_o(crdata),
        .o_csb0(csb0), .o_web0(web0), .o_wmask0(wmask0), .o_waddr0(waddr0),
        .o_din0(din0), .i_dout0(dout0)
    );

    sram_port0_arbiter #(.ADDR_W(9), .DATA_W(32), .READ_LAT(2)) u_dut_lat2 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(b_cyc), .wbs_stb_i(b_stb), .wbs_we_i(1'b0), .wbs_sel_i(4'b0000),
        .wbs_adr_i(b_adr), .wbs_dat_i(32'h0), .wbs_ack_o(b_ack), .wbs_dat_o(b_dato),
        .c_req_i(1'b0), .c_we_i(1'b0), .c_wmask_i(4'b0000), .c_addr_i(9'h0),
        .c_wdata_i(32'h0), .c_gnt_o(b_gnt), .c_rvalid_o(b_rvalid), .c_rdata_o(b_rdata),
        .o_csb0(b_csb), .o_web0(b_web), .o_wmask0(b_wmask), .o_waddr0(b_waddr),
        .o_din0(b_din), .i_dout0(b_dout)
    );

    // Behavioural SRAM A: read data valid one cycle after the command edge.
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) mem_a[waddr0][8*b +: 8] <= din0[8*b +: 8];
            end else begin
                dout0 <= mem_a[waddr0];
            end
        end
    end

    // Behavioural SRAM B: read data valid two cycles after the command edge.
    always @(posedge clk) begin
        if (!b_csb && b_web) b_rd1 <= mem_b[b_waddr];
        b_dout <= b_rd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
    endtask

    task automatic wb_idle();
        cyc = 0; stb = 0; we = 0;
    endtask

    int exp_own [4] = '{0, 1, 0, 1};
    int ng;
    logic seen;

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[511] = 32'hCAFE_F00D;
        mem_b[4]   = 32'h0000_BEEF;

        step(); step();
        check("rst_csb0", 32'(csb0), 32'd1);
        check("rst_web0", 32'(web0), 32'd1);
        check("rst_wmask0", 32'(wmask0), 32'd0);
        check("rst_waddr0", 32'(waddr0), 32'd0);
        check("rst_din0", din0, 32'd0);
        check("rst_resp", {26'd0, ack, gnt, rvalid, 3'd0}, 32'd0);
        check("rst_data", dat_o | crdata, 32'd0);
        rst = 0;
        step();

        // 1: WB write
        wb_drive(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0011);
        step();
        check("t1_csb0", 32'(csb0), 32'd0);
        check("t1_web0", 32'(web0), 32'd0);
        check("t1_waddr0", 32'(waddr0), 32'd4);
        check("t1_wmask0", 32'(wmask0), 32'b0011);
        check("t1_din0", din0, 32'hDEAD_BEEF);
        check("t1_ack_early", 32'(ack), 32'd0);
        step();
        check("t1_ack", 32'(ack), 32'd1);
        check("t1_csb0_done", 32'(csb0), 32'd1);
        wb_idle();
        step();
        check("t1_ack_pulse", 32'(ack), 32'd0);

        // 2: WB read back, upper bytes untouched
        wb_drive(0, 32'h0000_0010, 32'h0, 4'b1111);
        step();
        check("t2_csb0", 32'(csb0), 32'd0);
        check("t2_web0", 32'(web0), 32'd1);
        check("t2_wmask0", 32'(wmask0), 32'd0);
        step();
        check("t2_ack_wait", 32'(ack), 32'd0);
        step();
        check("t2_ack", 32'(ack), 32'd1);
        check("t2_dat", dat_o, 32'h0000_BEEF);
        wb_idle();
        step();

        // 3: both requesting from reset, held continuously
        rst = 1;
        step();
        rst = 0;
        wb_drive(1, 32'h0000_0020, 32'h1111_1111, 4'b1111);
        creq = 1; cwe = 1; cmask = 4'b1111; caddr = 9'd9; cwdata = 32'h2222_2222;
        ng = 0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            step();
            if (!csb0) begin
                check("t3_owner", 32'(gnt), 32'(exp_own[ng]));
                check("t3_addr", 32'(waddr0), (exp_own[ng] == 1) ? 32'd9 : 32'd8);
                ng++;
            end
        end
        check("t3_grants", 32'(ng), 32'd4);
        wb_idle();
        creq = 0;
        step(); step(); step();

        // 4: core read of top word, then WB wrap
        creq = 1; cwe = 0; caddr = 9'd511;
        step();
        check("t4_gnt", 32'(gnt), 32'd1);
        check("t4_waddr0", 32'(waddr0), 32'd511);
        check("t4_web0", 32'(web0), 32'd1);
        creq = 0;
        step();
        check("t4_rvalid_wait", 32'(rvalid), 32'd0);
        step();
        check("t4_rvalid", 32'(rvalid), 32'd1);
        check("t4_rdata", crdata, 32'hCAFE_F00D);
        check("t4_no_wb_ack", 32'(ack), 32'd0);
        step();
        check("t4_rvalid_pulse", 32'(rvalid), 32'd0);
        wb_drive(1, 32'h0000_0800, 32'h1234_5678, 4'b1111);
        step();
        check("t4_wrap_addr", 32'(waddr0), 32'd0);
        step();
        check("t4_wrap_ack", 32'(ack), 32'd1);
        wb_idle();
        step();

        // 5: cyc dropped during CMD, write still lands
        wb_drive(1, 32'h0000_0040, 32'hA5A5_A5A5, 4'b1111);
        step();
        check("t5_csb0", 32'(csb0), 32'd0);
        wb_idle();
        step();
        check("t5_no_ack", 32'(ack), 32'd0);
        step();
        wb_drive(0, 32'h0000_0040, 32'h0, 4'b1111);
        step(); step(); step();
        check("t5_readback_ack", 32'(ack), 32'd1);
        check("t5_readback", dat_o, 32'hA5A5_A5A5);
        wb_idle();
        step();

        // 6: reset during WAIT aborts the read
        wb_drive(0, 32'h0000_0010, 32'h0, 4'b1111);
        step();
        step();
        rst = 1;
        step();
        check("t6_csb0", 32'(csb0), 32'd1);
        check("t6_dat_rst", dat_o, 32'd0);
        rst = 0;
        wb_idle();
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            seen = seen | ack | rvalid | gnt;
            step();
        end
        check("t6_no_resp", 32'(seen), 32'd0);

        // READ_LAT=2 instance: ack one cycle later
        b_cyc = 1; b_stb = 1; b_adr = 32'h0000_0010;
        step();
        check("l2_csb0", 32'(b_csb), 32'd0);
        step();
        check("l2_ack_n2", 32'(b_ack), 32'd0);
        step();
        check("l2_ack_n3", 32'(b_ack), 32'd0);
        step();
        check("l2_ack_n4", 32'(b_ack), 32'd1);
        check("l2_dat", b_dato, 32'h0000_BEEF);
        b_cyc = 0; b_stb = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
